// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Operands are registered onto the ALU; the result is captured one EXEC cycle later.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [OPW-1:0]  req1_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_out,
  output logic            rsp0_zero,
  output logic            rsp0_neg,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_out,
  output logic            rsp1_zero,
  output logic            rsp1_neg,
  output logic [XLEN-1:0] alu_input1,
  output logic [XLEN-1:0] alu_input2,
  output logic [OPW-1:0]  alu_operation,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_negative,
  output logic            busy
);
  localparam logic [OPW-1:0] OP_NOP = '0;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, grant_q;
  logic                   gnt_vld, gnt_sel;
  logic [1:0]             req_valid, rsp_ready, elig;
  logic [1:0][XLEN-1:0]   req_a, req_b;
  logic [1:0][OPW-1:0]    req_op;
  logic [1:0]             rsp_valid_q, rsp_zero_q, rsp_neg_q;
  logic [1:0][XLEN-1:0]   rsp_out_q;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a     = {req1_a, req0_a};
  assign req_b     = {req1_b, req0_b};
  assign req_op    = {req1_op, req0_op};

  // A requester may issue only if its response slot is free or draining now.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    state_d = state_q;
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          gnt_vld = 1'b1;
          gnt_sel = (&elig) ? ~last_grant_q : elig[1];
          state_d = EXEC;
        end
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = gnt_vld & ~gnt_sel;
  assign req1_ready = gnt_vld &  gnt_sel;
  assign busy       = (state_q == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      alu_input1    <= '0;
      alu_input2    <= '0;
      alu_operation <= OP_NOP;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        alu_input1    <= req_a[gnt_sel];
        alu_input2    <= req_b[gnt_sel];
        alu_operation <= req_op[gnt_sel];
        grant_q       <= gnt_sel;
      end else begin
        // Operands hold so the ALU inputs stay quiet between ops.
        alu_operation <= OP_NOP;
        if (state_q == EXEC) last_grant_q <= grant_q;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    localparam logic IDX = 1'(i);
    always_ff @(posedge clk) begin
      if (rst) begin
        rsp_valid_q[i] <= 1'b0;
        rsp_out_q[i]   <= '0;
        rsp_zero_q[i]  <= 1'b0;
        rsp_neg_q[i]   <= 1'b0;
      end else if (state_q == EXEC && grant_q == IDX) begin
        // A capture overrides a simultaneous drain of the same slot.
        rsp_valid_q[i] <= 1'b1;
        rsp_out_q[i]   <= alu_out;
        rsp_zero_q[i]  <= alu_zero;
        rsp_neg_q[i]   <= alu_negative;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_q[i] <= 1'b0;
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_out   = rsp_out_q[0];
  assign rsp0_zero  = rsp_zero_q[0];
  assign rsp0_neg   = rsp_neg_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_out   = rsp_out_q[1];
  assign rsp1_zero  = rsp_zero_q[1];
  assign rsp1_neg   = rsp_neg_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small stand-in ALU
// (ADD=8, SUB=10, XOR=4, AND=7 chosen for this bench).
module tb_alu_share_arbiter;
  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]  req0_op, req1_op;
  logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [XLEN-1:0] rsp0_out, rsp1_out;
  logic            rsp0_zero, rsp1_zero, rsp0_neg, rsp1_neg;
  logic [XLEN-1:0] alu_input1, alu_input2, alu_out;
  logic [OPW-1:0]  alu_operation;
  logic            alu_zero, alu_negative, busy;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero), .rsp0_neg(rsp0_neg),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero), .rsp1_neg(rsp1_neg),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_operation(alu_operation),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_operation)
      4'd8:    alu_out = alu_input1 + alu_input2;
      4'd10:   alu_out = alu_input1 - alu_input2;
      4'd4:    alu_out = alu_input1 ^ alu_input2;
      4'd7:    alu_out = alu_input1 & alu_input2;
      default: alu_out = '0;
    endcase
    alu_zero     = (alu_out == '0);
    alu_negative = alu_out[XLEN-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_op", 64'(alu_operation), 0);
    chk("rst_in1", 64'(alu_input1), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rspv", 64'({rsp1_valid, rsp0_valid}), 0);
    chk("rst_out0", 64'(rsp0_out), 0);

    // 1: single ADD from req0
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'd8; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("t1_rdy", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 0;
    #1;
    chk("t1_busy", 64'(busy), 1);
    chk("t1_op", 64'(alu_operation), 8);
    chk("t1_in1", 64'(alu_input1), 5);
    chk("t1_rdy_exec", 64'({req1_ready, req0_ready}), 0);
    tick();
    chk("t1_v0", 64'(rsp0_valid), 1);
    chk("t1_out", 64'(rsp0_out), 12);
    chk("t1_flags", 64'({rsp0_zero, rsp0_neg}), 0);
    chk("t1_v1", 64'(rsp1_valid), 0);
    chk("t1_op_nop", 64'(alu_operation), 0);
    tick();
    chk("t1_drain", 64'(rsp0_valid), 0);
    chk("t1_hold", 64'(rsp0_out), 12);

    // 2: contention after reset, grants alternate starting with req0
    rst = 1; tick(); rst = 0;
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_op = 4'd10;
    req1_valid = 1; req1_a = 32'hFF; req1_b = 32'hFF; req1_op = 4'd4;
    #1;
    chk("t2_g0", 64'({req1_ready, req0_ready}), 64'b01);
    tick(); tick();
    chk("t2_v0", 64'(rsp0_valid), 1);
    chk("t2_out0", 64'(rsp0_out), 64'hFFFF_FFFE);
    chk("t2_neg0", 64'({rsp0_zero, rsp0_neg}), 64'b01);
    chk("t2_g1", 64'({req1_ready, req0_ready}), 64'b10);
    tick(); tick();
    chk("t2_v1", 64'(rsp1_valid), 1);
    chk("t2_out1", 64'(rsp1_out), 0);
    chk("t2_zero1", 64'({rsp1_zero, rsp1_neg}), 64'b10);
    chk("t2_g2", 64'({req1_ready, req0_ready}), 64'b01);
    tick(); tick();
    chk("t2_g3", 64'({req1_ready, req0_ready}), 64'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();

    // 3: stalled rsp0 makes req0 ineligible; req1 keeps being served
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 4'd8;
    tick(); tick();
    chk("t3_v0_held", 64'(rsp0_valid), 1);
    req1_valid = 1; req1_a = 2; req1_b = 2; req1_op = 4'd8;
    #1;
    chk("t3_g1a", 64'({req1_ready, req0_ready}), 64'b10);
    tick(); tick();
    chk("t3_out1", 64'(rsp1_out), 4);
    chk("t3_g1b", 64'({req1_ready, req0_ready}), 64'b10);
    chk("t3_out0_held", 64'(rsp0_out), 3);
    tick(); tick();
    rsp0_ready = 1;
    #1;
    chk("t3_g0_unstall", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t3_v0_new", 64'(rsp0_valid), 1);
    tick(); tick();

    // 4: reset during EXEC discards the op
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 4'd8;
    tick();
    req1_valid = 0; rst = 1;
    #1;
    chk("t4_busy_exec", 64'(busy), 1);
    tick();
    rst = 0;
    #1;
    chk("t4_busy", 64'(busy), 0);
    chk("t4_v1", 64'(rsp1_valid), 0);
    chk("t4_op", 64'(alu_operation), 0);
    tick(); tick();
    chk("t4_no_stale", 64'({rsp1_valid, rsp0_valid}), 0);

    // 5: issue while the old response drains in the same cycle
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'd8;
    tick();
    req0_valid = 0;
    tick();
    chk("t5_old", 64'(rsp0_out), 12);
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 4'd7; rsp0_ready = 1;
    #1;
    chk("t5_rdy", 64'(req0_ready), 1);
    tick();
    req0_valid = 0;
    #1;
    chk("t5_consumed", 64'(rsp0_valid), 0);
    tick();
    chk("t5_v0", 64'(rsp0_valid), 1);
    chk("t5_out", 64'(rsp0_out), 64'h30);

    // 6: idle for 10 cycles
    rsp0_ready = 0; rsp1_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_op", 64'(alu_operation), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_rdy", 64'({req1_ready, req0_ready}), 0);
    chk("t6_in", 64'({alu_input1, alu_input2}), {32'hF0, 32'h3C});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
